fft_peak_detect: RTL

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

---
 rtl/fft_peak_detect.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fft_peak_detect.sv
// Per-bin power (re^2 + im^2) of a streaming FFT output, plus a per-frame peak search.
// The frame peak (index and power) and a running frame count are reported once per frame.
module fft_peak_detect #(
  parameter int N       = 1024,
  parameter int WIDTH   = 32,
  parameter int SKIP_DC = 1,
  localparam int NN     = $clog2(N)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 di_en,
  input  logic [WIDTH-1:0]     di_re,
  input  logic [WIDTH-1:0]     di_im,
  output logic                 pw_en,
  output logic [2*WIDTH-1:0]   pw_data,
  output logic [NN-1:0]        pw_idx,
  output logic                 pk_en,
  output logic [NN-1:0]        pk_idx,
  output logic [2*WIDTH-1:0]   pk_pow,
  output logic [15:0]          frame_cnt
);

  localparam logic [NN-1:0] LAST_BIN = NN'(N - 1);

  logic [NN-1:0]             bin_cnt;

  logic                      s1_en;
  logic signed [WIDTH-1:0]   s1_re;
  logic signed [WIDTH-1:0]   s1_im;
  logic [NN-1:0]             s1_idx;

  logic                      s2_en;
  logic signed [2*WIDTH-1:0] s2_rr;
  logic signed [2*WIDTH-1:0] s2_ii;
  logic [NN-1:0]             s2_idx;

  logic signed [2*WIDTH-1:0] re_ext;
  logic signed [2*WIDTH-1:0] im_ext;

  logic [2*WIDTH-1:0]        hold_pow;
  logic [NN-1:0]             hold_idx;
  logic [2*WIDTH-1:0]        cand_pow;
  logic [NN-1:0]             cand_idx;

  // Widen before multiplying so the signed product keeps all 2*WIDTH bits.
  assign re_ext = s1_re;
  assign im_ext = s1_im;

  // Bin counter: N is a power of two, so the natural NN-bit wrap goes N-1 -> 0.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bin_cnt <= '0;
    end else if (di_en) begin
      bin_cnt <= bin_cnt + 1'b1;
    end
  end

  // Three-stage power pipeline: capture, square, sum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_en   <= 1'b0;
      s1_re   <= '0;
      s1_im   <= '0;
      s1_idx  <= '0;
      s2_en   <= 1'b0;
      s2_rr   <= '0;
      s2_ii   <= '0;
      s2_idx  <= '0;
      pw_en   <= 1'b0;
      pw_data <= '0;
      pw_idx  <= '0;
    end else begin
      s1_en   <= di_en;
      s1_re   <= di_re;
      s1_im   <= di_im;
      s1_idx  <= bin_cnt;
      s2_en   <= s1_en;
      s2_rr   <= re_ext * re_ext;
      s2_ii   <= im_ext * im_ext;
      s2_idx  <= s1_idx;
      pw_en   <= s2_en;
      // Both squares are non-negative and at most 2^(2W-2), so the sum fits unsigned.
      pw_data <= $unsigned(s2_rr) + $unsigned(s2_ii);
      pw_idx  <= s2_idx;
    end
  end

  // Peak candidate including the bin currently on the power output.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    cand_pow = hold_pow;
    cand_idx = hold_idx;
    if (pw_idx == '0) begin
      cand_pow = (SKIP_DC != 0) ? '0 : pw_data;
      cand_idx = '0;
    end else if (pw_data > hold_pow) begin
      cand_pow = pw_data;
      cand_idx = pw_idx;
    end
  end

  // Running peak, plus the reported result. The reported result is a separate register
  // set, so reloading on bin 0 of the next frame leaves the previous report untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_pow  <= '0;
      hold_idx  <= '0;
      pk_en     <= 1'b0;
      pk_idx    <= '0;
      pk_pow    <= '0;
      frame_cnt <= '0;
    end else begin
      pk_en <= 1'b0;
      if (pw_en) begin
        hold_pow <= cand_pow;
        hold_idx <= cand_idx;
        if (pw_idx == LAST_BIN) begin
          pk_en     <= 1'b1;
          pk_idx    <= cand_idx;
          pk_pow    <= cand_pow;
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end

endmodule
